// File: rtl/gcd_operand_driver.sv
// Requester-side front end for the subtractive GCD core: accepts operand pairs,
// sequences start/A/B onto the shared data bus, and returns the result or a timeout.
module gcd_operand_driver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             start_q, start_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    // Outputs are computed for the state being entered, so each register
    // already shows the new state's values in the first cycle of that state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        start_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if ((in_a != '0) && (in_b != '0)) begin
                        state_d = S_START;
                        start_d = 1'b1;
                        data_d  = in_a;
                    end else begin
                        // The core never terminates on a zero operand; gcd(x,0)=x.
                        state_d = S_RESP;
                        gcd_d   = in_a | in_b;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        data_d  = '0;
                    end
                end
            end
            S_START: begin
                state_d = S_LOAD_A;
                data_d  = a_q;
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
                data_d  = b_q;
            end
            S_LOAD_B: begin
                state_d = S_WAIT;
                data_d  = b_q;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (gcd_done) begin
                    state_d = S_RESP;
                    gcd_d   = gcd_result;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    data_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign out_gcd   = gcd_q;
    assign out_err   = err_q;
    assign gcd_start = start_q;
    assign gcd_data  = data_q;

endmodule

// File: tb/tb_gcd_operand_driver.sv
// Bench for gcd_operand_driver: a behavioural core stand-in with programmable latency,
// a table of directed pairs, hand-written reset sequence and random pairs vs a reference.
module tb_gcd_operand_driver;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         gcd_start;
    logic [W-1:0] gcd_data;
    logic [W-1:0] gcd_result = '0;
    logic         gcd_done = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gcd_operand_driver #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
        .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_result(gcd_result), .gcd_done(gcd_done)
    );

    always #5 clk = ~clk;

    // Core stand-in: start clears done, A is taken the cycle after start, B the next,
    // then done rises core_lat cycles after B was shown and stays high until the next start.
    int           core_phase = 0;
    int           core_cnt   = 0;
    int           core_lat   = 4;
    bit           core_hang  = 1'b0;
    logic [W-1:0] core_a = '0;
    logic [W-1:0] core_b = '0;

    function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p = x;
        logic [W-1:0] q = y;
        while (p != q) begin
            if (p > q) p = p - q;
            else       q = q - p;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (gcd_start) begin
            gcd_done   <= 1'b0;
            core_phase <= 1;
        end else begin
            case (core_phase)
                1: begin
                    core_a     <= gcd_data;
                    core_phase <= 2;
                end
                2: begin
                    core_b <= gcd_data;
                    if (core_hang) begin
                        core_phase <= 0;
                    end else if (core_lat <= 1) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= sub_gcd(core_a, gcd_data);
                        core_phase <= 0;
                    end else begin
                        core_cnt   <= core_lat - 1;
                        core_phase <= 3;
                    end
                end
                3: begin
                    core_cnt <= core_cnt - 1;
                    if (core_cnt == 1) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= sub_gcd(core_a, core_b);
                        core_phase <= 0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference model: what the requester should see for a pair, given how the core behaves.
    function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p = x;
        logic [W-1:0] q = y;
        logic [W-1:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic ref_expect(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                              input bit hang, output logic [W-1:0] g, output bit e);
        if (a == 0 || b == 0) begin
            g = a | b; e = 1'b0;
        end else if (hang || lat > TO) begin
            g = '0; e = 1'b1;
        end else begin
            g = euclid(a, b); e = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                            input bit hang, input int hold, input logic [W-1:0] eg,
                            input bit ee, input bit keep, input logic [W-1:0] na,
                            input logic [W-1:0] nb);
        int k;
        int bad;
        int exp_k;
        core_lat  = lat;
        core_hang = hang;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        check("accept_ready", in_ready, 1);
        tick();
        if (keep) begin
            in_a = na;
            in_b = nb;
        end else begin
            in_valid = 1'b0;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
        end
        check("busy_in_ready", in_ready, 0);
        if (a == 0 || b == 0) begin
            check("zero_valid_t1", out_valid, 1);
            check("zero_no_start", gcd_start, 0);
        end else begin
            check("start_pulse", gcd_start, 1);
            check("data_a_t1", gcd_data, a);
            tick();
            check("start_low", gcd_start, 0);
            check("data_a_t2", gcd_data, a);
            tick();
            check("data_b_t3", gcd_data, b);
            k = 0;
            bad = 0;
            while (!out_valid && k < 60) begin
                tick();
                k++;
                if (gcd_start) bad++;
                if (!out_valid && gcd_data !== b) bad++;
            end
            exp_k = (hang || lat > TO) ? TO + 1 : lat + 1;
            check("result_latency", k, exp_k);
            check("wait_bus_clean", bad, 0);
        end
        check("out_gcd", out_gcd, eg);
        check("out_err", out_err, ee);
        check("resp_data_zero", gcd_data, 0);
        for (int i = 1; i <= hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_gcd", out_gcd, eg);
            check("hold_err", out_err, ee);
            check("hold_in_ready", in_ready, 0);
            if (i == hold) out_ready = 1'b1;
        end
        tick();
        check("valid_dropped", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_no_start", gcd_start, 0);
        $display("pair a=%0d b=%0d lat=%0d hang=%0d -> gcd=%0d err=%0d", a, b, lat, hang, eg, ee);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        bit           hang;
        int           hold;
        logic [W-1:0] g;
        bit           e;
        bit           keep;
    } vec_t;

    localparam int NV = 12;
    vec_t tv[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] eg;
        bit           ee;
        int           k;
        int           rlat;
        bit           rhang;

        tv[0]  = '{16'd56,    16'd98,  6,  1'b0, 0, 16'd14,  1'b0, 1'b0};
        tv[1]  = '{16'd0,     16'd35,  3,  1'b0, 0, 16'd35,  1'b0, 1'b0};
        tv[2]  = '{16'd0,     16'd0,   3,  1'b0, 0, 16'd0,   1'b0, 1'b0};
        tv[3]  = '{16'd48,    16'd18,  4,  1'b0, 6, 16'd6,   1'b0, 1'b0};
        tv[4]  = '{16'd1234,  16'd77,  3,  1'b1, 1, 16'd0,   1'b1, 1'b0};
        tv[5]  = '{16'd7,     16'd21,  3,  1'b0, 0, 16'd7,   1'b0, 1'b0};
        tv[6]  = '{16'd100,   16'd75,  20, 1'b0, 0, 16'd25,  1'b0, 1'b0};
        tv[7]  = '{16'd100,   16'd75,  21, 1'b0, 0, 16'd0,   1'b1, 1'b0};
        tv[8]  = '{16'd56,    16'd98,  5,  1'b0, 0, 16'd14,  1'b0, 1'b1};
        tv[9]  = '{16'd17,    16'd5,   2,  1'b0, 0, 16'd1,   1'b0, 1'b1};
        tv[10] = '{16'd65535, 16'd255, 9,  1'b0, 0, 16'd255, 1'b0, 1'b0};
        tv[11] = '{16'd35,    16'd0,   1,  1'b0, 2, 16'd35,  1'b0, 1'b0};

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_gcd", out_gcd, 0);
        check("rst_gcd_start", gcd_start, 0);
        check("rst_gcd_data", gcd_data, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < NV; i++) begin
            na = (i + 1 < NV) ? tv[i+1].a : '0;
            nb = (i + 1 < NV) ? tv[i+1].b : '0;
            run_pair(tv[i].a, tv[i].b, tv[i].lat, tv[i].hang, tv[i].hold,
                     tv[i].g, tv[i].e, tv[i].keep, na, nb);
        end

        // Reset in the middle of a WAIT; the core's late done must not leak out.
        core_lat  = 15;
        core_hang = 1'b0;
        in_a      = 16'd1000;
        in_b      = 16'd250;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_err", out_err, 0);
        check("midrst_out_gcd", out_gcd, 0);
        check("midrst_gcd_start", gcd_start, 0);
        check("midrst_gcd_data", gcd_data, 0);
        check("midrst_in_ready", in_ready, 1);
        k = 0;
        repeat (20) begin
            tick();
            if (out_valid || gcd_start) k++;
        end
        check("midrst_quiet", k, 0);
        check("midrst_stale_done", gcd_done, 1);
        $display("reset during WAIT of 1000,250 abandoned cleanly");
        run_pair(16'd9, 16'd12, 3, 1'b0, 0, 16'd3, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(1, 65535));
            rb = W'($urandom_range(1, 2000));
            if ($urandom_range(0, 5) == 0) ra = '0;
            if ($urandom_range(0, 5) == 0) rb = '0;
            rlat  = $urandom_range(1, 23);
            rhang = ($urandom_range(0, 7) == 0);
            ref_expect(ra, rb, rlat, rhang, eg, ee);
            run_pair(ra, rb, rlat, rhang, $urandom_range(0, 3), eg, ee, 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
